// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes OP / OP-IMM / LUI / AUIPC into ALU operands and function code,
// then buffers the result in a head + skid register pair with valid/ready on both sides.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic [3:0]      ALU_func,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  localparam logic [3:0] F_SLL  = 4'd0;
  localparam logic [3:0] F_SRL  = 4'd1;
  localparam logic [3:0] F_SRA  = 4'd2;
  localparam logic [3:0] F_ADD  = 4'd3;
  localparam logic [3:0] F_SUB  = 4'd4;
  localparam logic [3:0] F_XOR  = 4'd5;
  localparam logic [3:0] F_OR   = 4'd6;
  localparam logic [3:0] F_AND  = 4'd7;
  localparam logic [3:0] F_SLT  = 4'd8;
  localparam logic [3:0] F_SLTU = 4'd9;
  localparam logic [3:0] F_LUI  = 4'd10;

  typedef struct packed {
    logic [3:0]      func;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{F_ADD, {XLEN{1'b0}}, {XLEN{1'b0}}, 5'd0, 1'b0, 1'b0};

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [3:0]      func_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] op2_s;
  logic            ill_s;
  logic            alt_s;
  logic            unused_s;
  entry_t          dec_s;

  entry_t          head_r;
  entry_t          skid_r;
  logic            head_valid_r;
  logic            skid_valid_r;
  logic            inst_ready_r;
  logic            accept_s;
  logic            leave_s;

  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];
  assign funct7_s = inst[31:25];
  assign alt_s    = (funct7_s == 7'b0100000);
  assign unused_s = ^inst[19:15];

  // Instruction decode into function code and raw operands
  always_comb begin
    func_s = F_ADD;
    op1_s  = {XLEN{1'b0}};
    op2_s  = {XLEN{1'b0}};
    ill_s  = 1'b0;
    case (funct3_s)
      3'b000:  func_s = F_ADD;
      3'b001:  func_s = F_SLL;
      3'b010:  func_s = F_SLT;
      3'b011:  func_s = F_SLTU;
      3'b100:  func_s = F_XOR;
      3'b101:  func_s = F_SRL;
      3'b110:  func_s = F_OR;
      3'b111:  func_s = F_AND;
      default: func_s = F_ADD;
    endcase
    case (opcode_s)
      7'b0110011: begin
        op1_s = rs1_data;
        op2_s = rs2_data;
        if (funct7_s == 7'b0000000) begin
          ill_s = 1'b0;
        end else if (alt_s && (funct3_s == 3'b000)) begin
          func_s = F_SUB;
        end else if (alt_s && (funct3_s == 3'b101)) begin
          func_s = F_SRA;
        end else begin
          ill_s = 1'b1;
        end
      end
      7'b0010011: begin
        op1_s = rs1_data;
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          // shift-immediates carry a 5-bit shamt; inst[31:25] selects SRAI or must be zero
          op2_s = {27'd0, inst[24:20]};
          if (funct7_s == 7'b0000000) begin
            ill_s = 1'b0;
          end else if (alt_s && (funct3_s == 3'b101)) begin
            func_s = F_SRA;
          end else begin
            ill_s = 1'b1;
          end
        end else begin
          op2_s = {{20{inst[31]}}, inst[31:20]};
        end
      end
      7'b0110111: begin
        func_s = F_LUI;
        op2_s  = {inst[31:12], 12'd0};
      end
      7'b0010111: begin
        func_s = F_ADD;
        op1_s  = pc;
        op2_s  = {inst[31:12], 12'd0};
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Any decode failure collapses to a harmless ADD 0,0 with no write-back
  assign dec_s.func      = ill_s ? F_ADD : func_s;
  assign dec_s.op1       = ill_s ? {XLEN{1'b0}} : op1_s;
  assign dec_s.op2       = ill_s ? {XLEN{1'b0}} : op2_s;
  assign dec_s.rd        = inst[11:7];
  assign dec_s.illegal   = ill_s;
  assign dec_s.reg_write = !ill_s && (inst[11:7] != 5'd0);

  assign accept_s = inst_valid && inst_ready_r;
  assign leave_s  = head_valid_r && alu_ready;

  // Head/skid buffer; ready tracks the skid slot and is itself registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      inst_ready_r <= 1'b1;
      head_r       <= RESET_ENTRY;
      skid_r       <= RESET_ENTRY;
    end else if (flush) begin
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      inst_ready_r <= 1'b1;
    end else if (!head_valid_r || leave_s) begin
      if (skid_valid_r) begin
        head_r       <= skid_r;
        head_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
        inst_ready_r <= 1'b1;
      end else if (accept_s) begin
        head_r       <= dec_s;
        head_valid_r <= 1'b1;
      end else begin
        head_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
      inst_ready_r <= 1'b0;
    end
  end

  assign inst_ready = inst_ready_r;
  assign alu_valid  = head_valid_r;
  assign ALU_func   = head_r.func;
  assign op1        = head_r.op1;
  assign op2        = head_r.op2;
  assign rd         = head_r.rd;
  assign reg_write  = head_r.reg_write;
  assign illegal    = head_r.illegal;

endmodule
